fp32_to_fp24_issue: RTL and testbench

//  Operand issue/convert stage sitting directly upstream of the fp24 add/sub/max/min unit.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp32_round_pre.sv | 39 +++
 rtl/fp32_to_fp24_issue.sv | 123 ++++++++++++
 tb/tb_fp32_to_fp24_issue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared fp24 definitions: format constants, op codes, operand classes and
// the pre-rounded operand record passed from the round stage to the packer.
package fp_pkg;

    localparam int FP24_W     = 24;
    localparam int FP24_EXP_W = 8;
    localparam int FP24_MAN_W = 15;

    localparam logic [FP24_EXP_W-1:0] FP24_EXP_MAX  = 8'hFF;
    localparam logic [FP24_MAN_W-1:0] FP24_QNAN_MAN = 15'h4000;

    // Op codes of the downstream unit; bit 2 turns ADD into SUB.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MAX = 2'd1,
        OP_MIN = 2'd2
    } fp_op_t;

    localparam int OP_SUB_BIT = 2;

    // ZERO also covers binary32 denormals, which are flushed.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Operand after mantissa rounding, before exponent carry handling.
    typedef struct packed {
        logic                  s;
        logic [FP24_EXP_W-1:0] e;
        logic [16:0]           sum17;
        fp_class_t             cls;
        logic                  inexact;
    } fp24_pre_t;

    // Packed fp24 operand plus its overflow flag.
    typedef struct packed {
        logic [FP24_W-1:0] f;
        logic              overflow;
    } fp24_res_t;

endpackage

// File: rtl/fp32_round_pre.sv
// Combinational front half of the binary32 -> fp24 conversion: classifies the
// operand and rounds the 23-bit mantissa to 15 bits with round-to-nearest-even.
module fp32_round_pre
    import fp_pkg::*;
(
    input  logic [31:0] in_f,
    output fp24_pre_t   pre
);

    logic [14:0] keep;
    logic        guard;
    logic        sticky;
    logic        rup;

    assign keep   = in_f[22:8];
    assign guard  = in_f[7];
    assign sticky = |in_f[6:0];
    // Round up above the halfway point, or exactly at it when keep is odd.
    assign rup    = guard & (sticky | keep[0]);

    // Classify the operand and build the pre-rounded record.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        pre         = '0;
        pre.s       = in_f[31];
        pre.e       = in_f[30:23];
        pre.sum17   = {2'b00, keep} + {16'h0000, rup};
        pre.cls     = NORM;
        pre.inexact = guard | sticky;
        if (in_f[30:23] == 8'h00) begin
            pre.cls     = ZERO;
            pre.inexact = |in_f[22:0];
        end else if (in_f[30:23] == 8'hFF) begin
            pre.cls     = (in_f[22:0] == 23'h0) ? INF : NAN;
            pre.inexact = 1'b0;
        end
    end

endmodule

// File: rtl/fp32_to_fp24_issue.sv
// Operand issue stage: converts a binary32 operand pair to fp24 (RNE, denormals
// flushed) through a two-stage elastic pipeline ahead of the fp24 add/sub unit.
module fp32_to_fp24_issue
    import fp_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FTZ_IN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic [OP_W-1:0]      in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP24_W-1:0]    out_a,
    output logic [FP24_W-1:0]    out_b,
    output logic [OP_W-1:0]      out_op,
    output logic                 out_inexact,
    output logic                 out_overflow
);

    if (FTZ_IN != 1) begin : g_ftz_check
        $error("fp32_to_fp24_issue: only FTZ_IN = 1 is implemented");
    end

    // Stage 2 packing: resolves class and the rounding carry into the exponent.
    function automatic fp24_res_t finalize(input fp24_pre_t p);
        fp24_res_t  res;
        logic [8:0] e_inc;
        res   = '0;
        e_inc = {1'b0, p.e} + 9'd1;
        case (p.cls)
            ZERO: res.f = {p.s, 23'h0};
            INF:  res.f = {p.s, FP24_EXP_MAX, 15'h0};
            NAN:  res.f = {p.s, FP24_EXP_MAX, FP24_QNAN_MAN};
            default: begin
                if (p.sum17[16] | p.sum17[15]) begin
                    if (e_inc >= 9'd255) begin
                        res.f        = {p.s, FP24_EXP_MAX, 15'h0};
                        res.overflow = 1'b1;
                    end else begin
                        res.f = {p.s, e_inc[7:0], 15'h0};
                    end
                end else begin
                    res.f = {p.s, p.e, p.sum17[14:0]};
                end
            end
        endcase
        return res;
    endfunction

    fp24_pre_t       pre_a, pre_b;
    fp24_pre_t       s1_pre_a, s1_pre_b;
    logic [OP_W-1:0] s1_op;
    logic            s1_valid;
    logic            s1_adv;
    fp24_res_t       fin_a, fin_b;

    logic [FP24_W-1:0] s2_a, s2_b;
    logic [OP_W-1:0]   s2_op;
    logic              s2_inexact;
    logic              s2_overflow;
    logic              s2_valid;

    fp32_round_pre u_pre_a (.in_f(in_a), .pre(pre_a));
    fp32_round_pre u_pre_b (.in_f(in_b), .pre(pre_b));

    // A stage may load whenever its content is empty or moving on this cycle.
    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    assign fin_a = finalize(s1_pre_a);
    assign fin_b = finalize(s1_pre_b);

    // Pipeline registers for both stages; data only loads on an actual transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset too, so out_* read as zero after reset
            // instead of leaking a discarded pair.
            s1_valid    <= 1'b0;
            s1_pre_a    <= '0;
            s1_pre_b    <= '0;
            s1_op       <= '0;
            s2_valid    <= 1'b0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_op       <= '0;
            s2_inexact  <= 1'b0;
            s2_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking so stage 2 sees stage 1's old value in the same edge.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_pre_a <= pre_a;
                    s1_pre_b <= pre_b;
                    s1_op    <= in_op;
                end
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_a        <= fin_a.f;
                    s2_b        <= fin_b.f;
                    s2_op       <= s1_op;
                    s2_inexact  <= s1_pre_a.inexact | s1_pre_b.inexact;
                    s2_overflow <= fin_a.overflow | fin_b.overflow;
                end
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_a        = s2_a;
    assign out_b        = s2_b;
    assign out_op       = s2_op;
    assign out_inexact  = s2_inexact;
    assign out_overflow = s2_overflow;

endmodule

// File: tb/tb_fp32_to_fp24_issue.sv
// Scoreboard bench for fp32_to_fp24_issue: directed vectors, backpressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_fp32_to_fp24_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_a, out_b;
    logic [3:0]  out_op;
    logic        out_inexact, out_overflow;

    fp32_to_fp24_issue #(.OP_W(4), .FTZ_IN(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [3:0]  op;
        logic        inx;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    bit   rand_rdy   = 1'b0;
    bit   ready_force = 1'b1;
    bit   saw_not_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: scale the 23-bit fraction by 1/256 and round the remainder to nearest-even.
    function automatic void ref_conv(input logic [31:0] f, output logic [23:0] r,
                                     output logic inx, output logic ovf);
        int e, m, qt, rem;
        e   = int'(f[30:23]);
        m   = int'(f[22:0]);
        qt  = m / 256;
        rem = m % 256;
        inx = 1'b0;
        ovf = 1'b0;
        if (e == 0) begin
            r   = {f[31], 23'h0};
            inx = (m != 0);
        end else if (e == 255) begin
            r = (m == 0) ? {f[31], 8'hFF, 15'h0} : {f[31], 8'hFF, 15'h4000};
        end else begin
            if (rem > 128 || (rem == 128 && (qt % 2) == 1)) qt++;
            inx = (rem != 0);
            if (qt == 32768) begin
                qt = 0;
                e++;
            end
            if (e == 255) ovf = 1'b1;
            r = {f[31], 8'(e), 15'(qt)};
        end
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [7:0]  e;
        logic [22:0] m;
        int cat;
        cat = $urandom_range(0, 7);
        e = 8'($urandom_range(1, 254));
        m = 23'($urandom);
        case (cat)
            0: e = 8'h00;
            1: e = 8'hFF;
            2: begin e = 8'hFE; m[22:8] = 15'h7FFF; end
            3: m[7:0] = 8'h80;
            4: m[22:7] = 16'hFFFF;
            default: ;
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Drive one pair and push its expected response when the transfer happens.
    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [23:0] ea, input logic [23:0] eb,
                            input logic einx, input logic eovf, input bit lat);
        exp_t e;
        bit   done;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = '{a: ea, b: eb, op: op, inx: einx, ovf: eovf, acc: cyc, lat: lat};
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input bit lat);
        logic [23:0] ra, rb;
        logic ia, ib, oa, ob;
        ref_conv(a, ra, ia, oa);
        ref_conv(b, rb, ib, ob);
        send_exp(a, b, op, ra, rb, ia | ib, oa | ob, lat);
    endtask

    // out_ready driver: either random or the level requested by the main sequence.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares each delivered pair and checks that stalled outputs hold.
    logic        held = 1'b0;
    logic [23:0] h_a, h_b;
    logic [3:0]  h_op;
    logic        h_inx, h_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (!in_ready) saw_not_ready = 1'b1;
            if (held) begin
                check("hold_valid", {31'h0, out_valid}, 32'd1);
                check("hold_data", {out_a, out_op, out_inexact, out_overflow, 2'b00},
                      {h_a, h_op, h_inx, h_ovf, 2'b00});
                check("hold_b", {8'h0, out_b}, {8'h0, h_b});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    check("out_a", {8'h0, out_a}, {8'h0, e.a});
                    check("out_b", {8'h0, out_b}, {8'h0, e.b});
                    check("out_op", {28'h0, out_op}, {28'h0, e.op});
                    check("out_inexact", {31'h0, out_inexact}, {31'h0, e.inx});
                    check("out_overflow", {31'h0, out_overflow}, {31'h0, e.ovf});
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
            held = out_valid && !out_ready;
            h_a = out_a; h_b = out_b; h_op = out_op; h_inx = out_inexact; h_ovf = out_overflow;
        end
    end

    initial begin
        int sent_bp;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_data", {out_a, out_op, out_inexact, out_overflow, 2'b00}, 32'd0);
        check("rst_b", {8'h0, out_b}, 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors with expected values written out by hand.
        send_exp(32'h3F800000, 32'hBF800000, 4'd0, 24'h3F8000, 24'hBF8000, 1'b0, 1'b0, 1'b1);
        send_exp(32'h3F800080, 32'h3F800180, 4'd1, 24'h3F8000, 24'h3F8002, 1'b1, 1'b0, 1'b1);
        send_exp(32'h3FFFFF80, 32'h7F7FFFFF, 4'd2, 24'h400000, 24'h7F8000, 1'b1, 1'b1, 1'b1);
        send_exp(32'h80000001, 32'h3F800000, 4'd4, 24'h800000, 24'h3F8000, 1'b1, 1'b0, 1'b1);
        send_exp(32'h7FC00000, 32'hFF800000, 4'd6, 24'h7FC000, 24'hFF8000, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: six back-to-back pairs with a three-cycle downstream stall.
        saw_not_ready = 1'b0;
        sent_bp = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_f32(), rand_f32(), 4'(i), 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                ready_force = 1'b0;
                repeat (3) @(posedge clk);
                ready_force = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready_dropped", {31'h0, saw_not_ready}, 32'd1);
        check("bp_all_out", 32'(n_out - sent_bp), 32'd6);

        // Mid-stream reset with both stages holding a pair.
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(32'h40490FDB, 32'hC0000000, 4'd3, 1'b0);
        send(32'h3F800180, 32'h00400000, 4'd5, 1'b0);
        @(negedge clk);
        check("pre_rst_full", {30'h0, out_valid, in_ready}, 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_exp(32'h3F800000, 32'hBF800000, 4'd9, 24'h3F8000, 24'hBF8000, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random downstream readiness.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_f32(), rand_f32(), 4'($urandom), 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        ready_force = 1'b1;

        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
